// File: rtl/apb_node_pkg.sv
// Shared types and constants for the APB 1-to-N demux with per-transfer watchdog.
package apb_node_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DECERR = 2'd2,
        ST_TOUT   = 2'd3
    } state_e;

    // Read data returned upstream on decode errors and timeout aborts
    localparam int unsigned ERR_RDATA = 0;

    // Width of a slave index; a single slave still needs one bit
    function automatic int unsigned idx_width(input int unsigned nb);
        return (nb > 1) ? $clog2(nb) : 1;
    endfunction

endpackage

// File: rtl/apb_addr_decoder.sv
// Combinational priority range decoder: the lowest-index slave whose inclusive
// [start, end] window contains the address wins.
module apb_addr_decoder
    import apb_node_pkg::*;
#(
    parameter int unsigned NB_SLAVES      = 4,
    parameter int unsigned APB_ADDR_WIDTH = 32,
    parameter int unsigned IDX_W          = idx_width(NB_SLAVES)
) (
    input  logic [APB_ADDR_WIDTH-1:0]           addr_i,
    input  logic [NB_SLAVES*APB_ADDR_WIDTH-1:0] start_addr_i,
    input  logic [NB_SLAVES*APB_ADDR_WIDTH-1:0] end_addr_i,
    output logic                                hit_o,
    output logic [IDX_W-1:0]                    idx_o
);

    localparam int unsigned AW = APB_ADDR_WIDTH;

    // Scan from the top down so the lowest matching index is the last one written
    always_comb begin
        hit_o = 1'b0;
        idx_o = '0;
        for (int i = int'(NB_SLAVES) - 1; i >= 0; i--) begin
            if ((addr_i >= start_addr_i[i*AW +: AW]) && (addr_i <= end_addr_i[i*AW +: AW])) begin
                hit_o = 1'b1;
                idx_o = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/apb_node_tmo.sv
// APB3 1-to-NB_SLAVES demux with address-range decode, decode-error response and a
// per-transfer PREADY watchdog that aborts a stuck slave with PSLVERR.
//
// state     | meaning
// ----------+------------------------------------------------------------------
// ST_IDLE   | no transfer in flight; setup phase decoded combinationally
// ST_ACCESS | access phase to latched slave, responses muxed from that slave
// ST_DECERR | unmapped address; answer PREADY+PSLVERR while PENABLE is high
// ST_TOUT   | slave aborted after TIMEOUT_CYCLES waits; one-cycle error response
module apb_node_tmo
    import apb_node_pkg::*;
#(
    parameter int unsigned NB_SLAVES      = 4,
    parameter int unsigned APB_ADDR_WIDTH = 32,
    parameter int unsigned APB_DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic [NB_SLAVES*APB_ADDR_WIDTH-1:0] start_addr_i,
    input  logic [NB_SLAVES*APB_ADDR_WIDTH-1:0] end_addr_i,
    input  logic                                psel_i,
    input  logic                                penable_i,
    input  logic                                pwrite_i,
    input  logic [APB_ADDR_WIDTH-1:0]           paddr_i,
    input  logic [APB_DATA_WIDTH-1:0]           pwdata_i,
    output logic [APB_DATA_WIDTH-1:0]           prdata_o,
    output logic                                pready_o,
    output logic                                pslverr_o,
    output logic [NB_SLAVES-1:0]                psel_o,
    output logic                                penable_o,
    output logic                                pwrite_o,
    output logic [APB_ADDR_WIDTH-1:0]           paddr_o,
    output logic [APB_DATA_WIDTH-1:0]           pwdata_o,
    input  logic [NB_SLAVES*APB_DATA_WIDTH-1:0] prdata_i,
    input  logic [NB_SLAVES-1:0]                pready_i,
    input  logic [NB_SLAVES-1:0]                pslverr_i,
    output logic                                tmo_pulse_o,
    output logic [APB_ADDR_WIDTH-1:0]           err_addr_o
);

    localparam int unsigned IDX_W = idx_width(NB_SLAVES);
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned DW    = APB_DATA_WIDTH;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);

    state_e                    state_q, state_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [APB_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [APB_ADDR_WIDTH-1:0] err_addr_q, err_addr_d;

    logic                      dec_hit;
    logic [IDX_W-1:0]          dec_idx;
    logic                      slv_ready;
    logic                      slv_err;
    logic [DW-1:0]             slv_rdata;
    logic                      sel_en;
    logic [IDX_W-1:0]          sel_idx;

    apb_addr_decoder #(
        .NB_SLAVES      (NB_SLAVES),
        .APB_ADDR_WIDTH (APB_ADDR_WIDTH),
        .IDX_W          (IDX_W)
    ) u_decoder (
        .addr_i       (paddr_i),
        .start_addr_i (start_addr_i),
        .end_addr_i   (end_addr_i),
        .hit_o        (dec_hit),
        .idx_o        (dec_idx)
    );

    assign paddr_o    = paddr_i;
    assign pwdata_o   = pwdata_i;
    assign pwrite_o   = pwrite_i;
    assign err_addr_o = err_addr_q;

    // Response mux keyed on the index latched at setup, so a moving PADDR cannot re-route
    always_comb begin
        slv_ready = 1'b0;
        slv_err   = 1'b0;
        slv_rdata = '0;
        for (int i = 0; i < int'(NB_SLAVES); i++) begin
            if (idx_q == IDX_W'(i)) begin
                slv_ready = pready_i[i];
                slv_err   = pslverr_i[i];
                slv_rdata = prdata_i[i*DW +: DW];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            cnt_q      <= '0;
            addr_q     <= '0;
            err_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            err_addr_q <= err_addr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cnt_d      = '0;
        addr_d     = addr_q;
        err_addr_d = err_addr_q;
        case (state_q)
            ST_IDLE: begin
                if (psel_i) begin
                    idx_d  = dec_idx;
                    addr_d = paddr_i;
                    if (dec_hit) begin
                        state_d = ST_ACCESS;
                    end else begin
                        state_d    = ST_DECERR;
                        err_addr_d = paddr_i;
                    end
                end
            end
            ST_ACCESS: begin
                if (!psel_i) begin
                    state_d = ST_IDLE;
                end else if (penable_i) begin
                    if (slv_ready) begin
                        state_d = ST_IDLE;
                    end else if (cnt_q >= CNT_LAST) begin
                        state_d    = ST_TOUT;
                        err_addr_d = addr_q;
                    end else if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end else begin
                        cnt_d = cnt_q;
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            ST_DECERR: begin
                if (!psel_i || penable_i) begin
                    state_d = ST_IDLE;
                end
            end
            ST_TOUT: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        sel_en      = 1'b0;
        sel_idx     = idx_q;
        psel_o      = '0;
        penable_o   = 1'b0;
        pready_o    = 1'b0;
        pslverr_o   = 1'b0;
        prdata_o    = DW'(ERR_RDATA);
        tmo_pulse_o = 1'b0;
        case (state_q)
            ST_IDLE: begin
                sel_en  = psel_i & dec_hit;
                sel_idx = dec_idx;
            end
            ST_ACCESS: begin
                sel_en    = psel_i;
                penable_o = penable_i;
                pready_o  = slv_ready;
                pslverr_o = slv_err;
                prdata_o  = slv_rdata;
            end
            ST_DECERR: begin
                pready_o  = penable_i;
                pslverr_o = penable_i;
            end
            ST_TOUT: begin
                pready_o    = 1'b1;
                pslverr_o   = 1'b1;
                tmo_pulse_o = 1'b1;
            end
            default: begin
                sel_en = 1'b0;
            end
        endcase
        for (int i = 0; i < int'(NB_SLAVES); i++) begin
            psel_o[i] = sel_en && (sel_idx == IDX_W'(i));
        end
    end

endmodule
